// File: rtl/sram_port_arbiter_if.sv
// Requester-side handshake bundle for sram_port_arbiter: one instance per requester.
// The master modport is the requester; the slave modport is the arbiter.
interface sram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
);
  logic                  req_i;
  logic                  we_i;
  logic [NUM_WMASKS-1:0] wmask_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  gnt_o;
  logic                  rvalid_o;
  logic [DATA_WIDTH-1:0] rdata_o;

  modport master (
    output req_i, we_i, wmask_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, wmask_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing the OpenRAM RW port between requesters A and B.
// Define SRAM_RSP_REG_EN to register read data and deliver responses one cycle later.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  sram_port_arbiter_if.slave    a_if,
  sram_port_arbiter_if.slave    b_if,
  output logic                  sram_csb0_o,
  output logic                  sram_web0_o,
  output logic [NUM_WMASKS-1:0] sram_wmask0_o,
  output logic [ADDR_WIDTH-1:0] sram_addr0_o,
  output logic [DATA_WIDTH-1:0] sram_din0_o,
  input  logic [DATA_WIDTH-1:0] sram_dout0_i
);

`ifdef SRAM_RSP_REG_EN
  localparam int RSP_STAGES = 2;
`else
  localparam int RSP_STAGES = 1;
`endif

  logic                  r_ptr_b;
  logic                  w_gnt_a, w_gnt_b, w_gnt, w_we;
  logic [NUM_WMASKS-1:0] w_wmask, r_wmask;
  logic [ADDR_WIDTH-1:0] w_addr, r_addr;
  logic [DATA_WIDTH-1:0] w_din, r_din, w_rsp_data;
  logic [RSP_STAGES:1]   r_vld_pipe, r_side_pipe, r_we_pipe;

  // Grants are gated by reset so nothing reaches the macro while reset is held.
  assign w_gnt_a = rst_ni & a_if.req_i & (~b_if.req_i | ~r_ptr_b);
  assign w_gnt_b = rst_ni & b_if.req_i & (~a_if.req_i |  r_ptr_b);
  assign w_gnt   = w_gnt_a | w_gnt_b;

  assign w_we    = w_gnt_b ? b_if.we_i    : a_if.we_i;
  assign w_addr  = w_gnt_b ? b_if.addr_i  : a_if.addr_i;
  assign w_din   = w_gnt_b ? b_if.wdata_i : a_if.wdata_i;
  assign w_wmask = !w_we ? '0 : (w_gnt_b ? b_if.wmask_i : a_if.wmask_i);

  assign a_if.gnt_o = w_gnt_a;
  assign b_if.gnt_o = w_gnt_b;

  // Idle cycles replay the last issued values so the macro pins stay quiet.
  assign sram_csb0_o   = ~w_gnt;
  assign sram_web0_o   = ~(w_gnt & w_we);
  assign sram_wmask0_o = w_gnt ? w_wmask : r_wmask;
  assign sram_addr0_o  = w_gnt ? w_addr  : r_addr;
  assign sram_din0_o   = w_gnt ? w_din   : r_din;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr_b <= 1'b0;
      r_wmask <= '0;
      r_addr  <= '0;
      r_din   <= '0;
    end else if (w_gnt) begin
      r_ptr_b <= w_gnt_a;
      r_wmask <= w_wmask;
      r_addr  <= w_addr;
      r_din   <= w_din;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld_pipe[1]  <= 1'b0;
      r_side_pipe[1] <= 1'b0;
      r_we_pipe[1]   <= 1'b0;
    end else begin
      r_vld_pipe[1]  <= w_gnt;
      r_side_pipe[1] <= w_gnt_b;
      r_we_pipe[1]   <= w_we;
    end
  end

`ifdef SRAM_RSP_REG_EN
  logic [DATA_WIDTH-1:0] r_rdata;

  // Second stage: dout is captured at the edge where the macro holds it valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld_pipe[2]  <= 1'b0;
      r_side_pipe[2] <= 1'b0;
      r_we_pipe[2]   <= 1'b0;
      r_rdata        <= '0;
    end else begin
      r_vld_pipe[2]  <= r_vld_pipe[1];
      r_side_pipe[2] <= r_side_pipe[1];
      r_we_pipe[2]   <= r_we_pipe[1];
      if (r_vld_pipe[1] && !r_we_pipe[1]) r_rdata <= sram_dout0_i;
    end
  end

  assign w_rsp_data = r_we_pipe[RSP_STAGES] ? '0 : r_rdata;
`else
  assign w_rsp_data = r_we_pipe[RSP_STAGES] ? '0 : sram_dout0_i;
`endif

  assign a_if.rvalid_o = r_vld_pipe[RSP_STAGES] & ~r_side_pipe[RSP_STAGES];
  assign b_if.rvalid_o = r_vld_pipe[RSP_STAGES] &  r_side_pipe[RSP_STAGES];
  assign a_if.rdata_o  = a_if.rvalid_o ? w_rsp_data : '0;
  assign b_if.rdata_o  = b_if.rvalid_o ? w_rsp_data : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM plus a grant/memory/response-queue reference model.
module tb_sram_port_arbiter;
  localparam int AW = 8, DW = 32, MW = 4;
`ifdef SRAM_RSP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) a_if ();
  sram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) b_if ();

  logic          csb, web;
  logic [MW-1:0] wmask;
  logic [AW-1:0] addr;
  logic [DW-1:0] din, dout;

  sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .a_if(a_if), .b_if(b_if),
    .sram_csb0_o(csb), .sram_web0_o(web), .sram_wmask0_o(wmask),
    .sram_addr0_o(addr), .sram_din0_o(din), .sram_dout0_i(dout)
  );

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] nw, logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < MW; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Behavioural macro: inputs registered at posedge, array access at the following negedge.
  logic [DW-1:0] smem [256];
  logic          s_csb = 1'b1, s_web = 1'b1;
  logic [MW-1:0] s_wmask;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_din;
  always @(posedge clk) begin
    s_csb <= csb; s_web <= web; s_wmask <= wmask; s_addr <= addr; s_din <= din;
  end
  always @(negedge clk) begin
    if (!s_csb) begin
      if (!s_web) smem[s_addr] <= merge(smem[s_addr], s_din, s_wmask);
      else        dout <= smem[s_addr];
    end
  end

  // Reference model state
  typedef struct { int due; bit side; logic [DW-1:0] data; } rsp_t;
  rsp_t          rq[$];
  logic [DW-1:0] emem [256];
  bit            eptr_b;
  logic [MW-1:0] lwmask;
  logic [AW-1:0] laddr;
  logic [DW-1:0] ldin;
  int            cyc;
  logic          e_ga, e_gb, e_we;
  logic [MW-1:0] e_wm;
  logic [AW-1:0] e_ad;
  logic [DW-1:0] e_dn;
  logic [113:0]  e_vec, o_vec;
  int            errors = 0, checks = 0;

  assign o_vec = {a_if.gnt_o, b_if.gnt_o, csb, web, wmask, addr, din,
                  a_if.rvalid_o, b_if.rvalid_o, a_if.rdata_o, b_if.rdata_o};

  task automatic model_reset();
    rq.delete(); eptr_b = 1'b0; lwmask = '0; laddr = '0; ldin = '0;
  endtask

  task automatic idle_inputs();
    a_if.req_i = 0; a_if.we_i = 0; a_if.wmask_i = '0; a_if.addr_i = '0; a_if.wdata_i = '0;
    b_if.req_i = 0; b_if.we_i = 0; b_if.wmask_i = '0; b_if.addr_i = '0; b_if.wdata_i = '0;
  endtask

  task automatic set_a(bit we, logic [MW-1:0] m, logic [AW-1:0] ad, logic [DW-1:0] d);
    a_if.req_i = 1; a_if.we_i = we; a_if.wmask_i = m; a_if.addr_i = ad; a_if.wdata_i = d;
  endtask

  task automatic set_b(bit we, logic [MW-1:0] m, logic [AW-1:0] ad, logic [DW-1:0] d);
    b_if.req_i = 1; b_if.we_i = we; b_if.wmask_i = m; b_if.addr_i = ad; b_if.wdata_i = d;
  endtask

  // Evaluate expectations for the current cycle, away from the clock edges.
  task automatic settle();
    logic g, rva, rvb;
    logic [DW-1:0] rda, rdb;
    @(negedge clk); #2;
    e_ga = 0; e_gb = 0;
    if (rst_n) begin
      if (a_if.req_i && b_if.req_i) begin e_gb = eptr_b; e_ga = !eptr_b; end
      else begin e_ga = a_if.req_i; e_gb = b_if.req_i; end
    end
    g    = e_ga | e_gb;
    e_we = e_gb ? b_if.we_i : a_if.we_i;
    e_ad = !g ? laddr  : (e_gb ? b_if.addr_i  : a_if.addr_i);
    e_dn = !g ? ldin   : (e_gb ? b_if.wdata_i : a_if.wdata_i);
    e_wm = !g ? lwmask : (!e_we ? '0 : (e_gb ? b_if.wmask_i : a_if.wmask_i));
    rva = 0; rvb = 0; rda = '0; rdb = '0;
    foreach (rq[i]) if (rq[i].due == cyc) begin
      if (rq[i].side) begin rvb = 1; rdb = rq[i].data; end
      else            begin rva = 1; rda = rq[i].data; end
    end
    e_vec = {e_ga, e_gb, !g, !(g && e_we), e_wm, e_ad, e_dn, rva, rvb, rda, rdb};
  endtask

  // Commit this cycle's grant to the model and move past the clock edge.
  task automatic advance();
    rsp_t r;
    @(posedge clk); #1;
    if (e_ga || e_gb) begin
      r.due = cyc + LAT; r.side = e_gb; r.data = e_we ? '0 : emem[e_ad];
      rq.push_back(r);
      if (e_we) emem[e_ad] = merge(emem[e_ad], e_dn, e_wm);
      eptr_b = e_ga; laddr = e_ad; ldin = e_dn; lwmask = e_wm;
    end
    cyc++;
    while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    a_if.req_i = 1; b_if.req_i = 1;
    settle();
    checks++; if ({a_if.gnt_o, b_if.gnt_o} !== 2'b00)
      begin errors++; $display("FAIL reset_gnt got=%b want=00", {a_if.gnt_o, b_if.gnt_o}); end
    checks++; if ({csb, web, wmask, addr, din} !== {1'b1, 1'b1, 4'h0, 8'h00, 32'h0})
      begin errors++; $display("FAIL reset_macro got=%h", {csb, web, wmask, addr, din}); end
    checks++; if ({a_if.rvalid_o, b_if.rvalid_o, a_if.rdata_o, b_if.rdata_o} !== 66'h0)
      begin errors++; $display("FAIL reset_rsp got=%h want=0", {a_if.rvalid_o, b_if.rvalid_o, a_if.rdata_o, b_if.rdata_o}); end
    idle_inputs();
    #1 rst_n = 1;
    advance();
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] ad;
    ad = $urandom;
    for (int i = 0; i < 6 + LAT; i++) begin
      if (i < 6) begin
        set_a(1, 4'hF, 8'h20, ad);
        set_b(0, 4'h0, 8'h20, 32'h0);
      end else idle_inputs();
      settle();
      if (i < 6) begin
        checks++; if ({a_if.gnt_o, b_if.gnt_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
          begin errors++; $display("FAIL rr_gnt i=%0d got=%b", i, {a_if.gnt_o, b_if.gnt_o}); end
      end
      if (i >= LAT) begin
        checks++; if ({a_if.rvalid_o, b_if.rvalid_o} !== (((i - LAT) % 2 == 0) ? 2'b10 : 2'b01))
          begin errors++; $display("FAIL rr_rvalid i=%0d got=%b", i, {a_if.rvalid_o, b_if.rvalid_o}); end
      end
      checks++; if (o_vec !== e_vec)
        begin errors++; $display("FAIL rr_vec i=%0d got=%h want=%h", i, o_vec, e_vec); end
      advance();
      if (i < 6 && i % 2 == 0) ad = $urandom;
    end
  endtask

  task automatic test_write_read();
    for (int c = 0; c <= 1 + LAT; c++) begin
      idle_inputs();
      if (c == 0) set_a(1, 4'hF, 8'h10, 32'hDEADBEEF);
      if (c == 1) set_a(0, 4'hF, 8'h10, 32'h0);
      settle();
      if (c == 0) begin
        checks++; if ({a_if.gnt_o, csb, web, addr} !== {1'b1, 1'b0, 1'b0, 8'h10})
          begin errors++; $display("FAIL wr_issue got=%h", {a_if.gnt_o, csb, web, addr}); end
      end
      if (c == LAT) begin
        checks++; if ({a_if.rvalid_o, a_if.rdata_o} !== {1'b1, 32'h0})
          begin errors++; $display("FAIL wr_ack got=%h want=100000000", {a_if.rvalid_o, a_if.rdata_o}); end
      end
      if (c == 1 + LAT) begin
        checks++; if ({a_if.rvalid_o, a_if.rdata_o} !== {1'b1, 32'hDEADBEEF})
          begin errors++; $display("FAIL rd_after_wr got=%h want=1deadbeef", {a_if.rvalid_o, a_if.rdata_o}); end
      end
      checks++; if (o_vec !== e_vec)
        begin errors++; $display("FAIL wr_vec c=%0d got=%h want=%h", c, o_vec, e_vec); end
      advance();
    end
  endtask

  task automatic test_partial_write();
    for (int c = 0; c <= 1 + LAT; c++) begin
      idle_inputs();
      if (c == 0) set_b(1, 4'b0101, 8'h10, 32'h11223344);
      if (c == 1) set_b(0, 4'hF, 8'h10, 32'h0);
      settle();
      if (c == 0) begin
        checks++; if ({b_if.gnt_o, web, wmask} !== {1'b1, 1'b0, 4'b0101})
          begin errors++; $display("FAIL pw_issue got=%h", {b_if.gnt_o, web, wmask}); end
      end
      if (c == 1) begin
        checks++; if ({b_if.gnt_o, web, wmask} !== {1'b1, 1'b1, 4'b0000})
          begin errors++; $display("FAIL pw_read_mask got=%h", {b_if.gnt_o, web, wmask}); end
      end
      if (c == 1 + LAT) begin
        checks++; if ({b_if.rvalid_o, b_if.rdata_o, a_if.rdata_o} !== {1'b1, 32'hDE22BE44, 32'h0})
          begin errors++; $display("FAIL pw_data got=%h want=1de22be4400000000", {b_if.rvalid_o, b_if.rdata_o, a_if.rdata_o}); end
      end
      checks++; if (o_vec !== e_vec)
        begin errors++; $display("FAIL pw_vec c=%0d got=%h want=%h", c, o_vec, e_vec); end
      advance();
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 4 + LAT; c++) begin
      idle_inputs();
      if (c == 3) begin set_a(0, 4'h0, 8'h30, 32'h0); set_b(0, 4'h0, 8'h31, 32'h0); end
      settle();
      if (c < 3) begin
        checks++; if ({csb, web, a_if.rvalid_o, b_if.rvalid_o, wmask, addr} !== {4'b1100, 4'h0, 8'h10})
          begin errors++; $display("FAIL idle_quiet c=%0d got=%h", c, {csb, web, a_if.rvalid_o, b_if.rvalid_o, wmask, addr}); end
      end
      if (c == 3) begin
        checks++; if ({a_if.gnt_o, b_if.gnt_o} !== 2'b10)
          begin errors++; $display("FAIL idle_next_gnt got=%b want=10", {a_if.gnt_o, b_if.gnt_o}); end
      end
      checks++; if (o_vec !== e_vec)
        begin errors++; $display("FAIL idle_vec c=%0d got=%h want=%h", c, o_vec, e_vec); end
      advance();
    end
  endtask

  task automatic test_reset_inflight();
    idle_inputs();
    set_a(0, 4'h0, 8'h10, 32'h0);
    settle();
    checks++; if (a_if.gnt_o !== 1'b1)
      begin errors++; $display("FAIL rsti_gnt got=%b want=1", a_if.gnt_o); end
    advance();
    rst_n = 0;
    model_reset();
    settle();
    checks++; if ({a_if.rvalid_o, b_if.rvalid_o, csb, a_if.gnt_o} !== 4'b0010)
      begin errors++; $display("FAIL rsti_drop got=%b want=0010", {a_if.rvalid_o, b_if.rvalid_o, csb, a_if.gnt_o}); end
    advance();
    rst_n = 1;
    for (int c = 0; c < 2 + LAT; c++) begin
      idle_inputs();
      if (c == 1) begin set_a(0, 4'h0, 8'h11, 32'h0); set_b(0, 4'h0, 8'h12, 32'h0); end
      settle();
      if (c == 0) begin
        checks++; if ({a_if.rvalid_o, b_if.rvalid_o} !== 2'b00)
          begin errors++; $display("FAIL rsti_stale got=%b want=00", {a_if.rvalid_o, b_if.rvalid_o}); end
      end
      if (c == 1) begin
        checks++; if ({a_if.gnt_o, b_if.gnt_o} !== 2'b10)
          begin errors++; $display("FAIL rsti_ptr got=%b want=10", {a_if.gnt_o, b_if.gnt_o}); end
      end
      checks++; if (o_vec !== e_vec)
        begin errors++; $display("FAIL rsti_vec c=%0d got=%h want=%h", c, o_vec, e_vec); end
      advance();
    end
  endtask

  task automatic test_random();
    bit a_done = 1, b_done = 1;
    idle_inputs();
    for (int n = 0; n < 400 + LAT; n++) begin
      if (n >= 400) idle_inputs();
      else begin
        if (!a_if.req_i || a_done) begin
          a_if.req_i = ($urandom_range(0, 99) < 60); a_if.we_i = 1'($urandom_range(0, 1));
          a_if.wmask_i = 4'($urandom_range(0, 15)); a_if.addr_i = 8'($urandom_range(0, 7));
          a_if.wdata_i = $urandom;
        end else if ($urandom_range(0, 9) == 0) a_if.req_i = 0;
        if (!b_if.req_i || b_done) begin
          b_if.req_i = ($urandom_range(0, 99) < 60); b_if.we_i = 1'($urandom_range(0, 1));
          b_if.wmask_i = 4'($urandom_range(0, 15)); b_if.addr_i = 8'($urandom_range(0, 7));
          b_if.wdata_i = $urandom;
        end else if ($urandom_range(0, 9) == 0) b_if.req_i = 0;
      end
      settle();
      checks++; if (o_vec !== e_vec)
        begin errors++; $display("FAIL rand_vec n=%0d got=%h want=%h", n, o_vec, e_vec); end
      checks++; if ((a_if.gnt_o & b_if.gnt_o) | (a_if.gnt_o & ~a_if.req_i) | (b_if.gnt_o & ~b_if.req_i))
        begin errors++; $display("FAIL rand_gnt_rule n=%0d gnt=%b req=%b", n, {a_if.gnt_o, b_if.gnt_o}, {a_if.req_i, b_if.req_i}); end
      a_done = e_ga; b_done = e_gb;
      advance();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin smem[i] = '0; emem[i] = '0; end
    dout = '0;
    cyc = 0;
    model_reset();
    test_reset();
    test_round_robin();
    test_write_read();
    test_partial_write();
    test_idle();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the RW port (port 0) of the 256x32 OpenRAM SRAM macro between two requesters, A and B (e.g. LSU and debug/DMA), using req/gnt handshakes.
- Round-robin arbitration.
- Drives the macro's registered-input port 0 signals and returns one response per granted request, carrying read data or a write ack.
- Port 1 (read-only) is outside this block; the top level ties csb1 high or routes it elsewhere.

Parameters:
- ADDR_WIDTH, 8, word address width; must match the macro.
- DATA_WIDTH, 32, data word width.
- NUM_WMASKS, 4, byte-lane write mask width (DATA_WIDTH/8).

Ports:
- clk_i  input  1  clock; also drives the macro's clk0 at top level.
- rst_ni  input  1  asynchronous active-low reset.
- a_req_i  input  1  requester A request; held with payload until granted.
- a_we_i  input  1  1 = write, 0 = read.
- a_wmask_i  input  NUM_WMASKS  byte write enables.
- a_addr_i  input  ADDR_WIDTH  word address.
- a_wdata_i  input  DATA_WIDTH  write data.
- a_gnt_o  output  1  request accepted this cycle.
- a_rvalid_o  output  1  response valid.
- a_rdata_o  output  DATA_WIDTH  read data; 0 for write acks.
- b_req_i, b_we_i, b_wmask_i, b_addr_i, b_wdata_i, b_gnt_o, b_rvalid_o, b_rdata_o: same as A, for requester B.
- sram_csb0_o  output  1  macro chip select, active low.
- sram_web0_o  output  1  macro write enable, active low.
- sram_wmask0_o  output  NUM_WMASKS  macro write mask.
- sram_addr0_o  output  ADDR_WIDTH  macro address.
- sram_din0_o  output  DATA_WIDTH  macro write data.
- sram_dout0_i  input  DATA_WIDTH  macro read data.

Behaviour:
- Reset (asynchronous, rst_ni low):
  - all gnt/rvalid outputs = 0; rdata outputs = 0;
  - sram_csb0_o = 1, sram_web0_o = 1, sram_wmask0_o = 0, sram_addr0_o = 0, sram_din0_o = 0;
  - round-robin pointer = A preferred;
  - any in-flight response is dropped and not delivered after reset release.
- Arbitration (combinational in cycle N):
  - Only one requester asserting req: that requester is granted.
  - Both asserting: the pointer's preferred side is granted.
  - After each grant, the pointer moves to the non-granted side.
  - Pointer is unchanged when there is no grant.
  - At most one gnt is high per cycle. gnt never asserts without its req.
- Macro drive in cycle N, sampled by the macro at posedge closing cycle N:
  - With a grant: csb0 = 0, web0 = ~we, and wmask/addr/din are muxed from the granted requester.
  - With no grant: csb0 = 1, web0 = 1, other macro outputs hold their last values; no toggling on idle.
  - A read drives wmask0 = 0 regardless of requester wmask.
- Response:
  - Each grant in cycle N produces exactly one rvalid pulse to the same requester in cycle N+1.
  - Read response: rdata = sram_dout0_i, passed combinationally. The macro's dout0 is valid from negedge N + DELAY through posedge N+1 + T_HOLD, so the consumer samples it at the posedge closing N+1.
  - Write response: rdata = 0. The macro commits the write at negedge N.
  - rdata of the side not responding = 0.
  - Responses cannot be back-pressured; requesters must accept rvalid.
- Back-to-back operation: a new grant is allowed every cycle (full throughput).
  - Write in N followed by read of the same address in N+1 returns the new data, because the write completes at negedge N.
- Write mask 0 with we = 1: still issued and acked; memory unchanged.
- Requester drops req without a grant: legal. Nothing is issued; the pointer is unchanged.
- Pipeline tracking: 1-bit valid, 1-bit side id, 1-bit we for the response stage.

Optional Feature:
- SRAM_RSP_REG_EN defined:
  - Read data is captured into a register at the posedge closing N+1.
  - rvalid and rdata are delivered in cycle N+2, fully registered, so consumers see no combinational path from the macro.
  - Back-to-back throughput is retained with a 2-deep response pipeline of valid/id/we.
  - Reset clears both stages.
- Undefined: N+1 combinational response as in Behaviour.

Test Plan:
- Reset, then A writes addr 0x10, data 0xDEADBEEF, wmask 4'hF -> a_gnt_o=1 same cycle; csb0=0, web0=0; a_rvalid_o=1 next cycle with a_rdata_o=0.
- A reads 0x10 the cycle after the write -> a_rvalid_o=1 at N+1 with a_rdata_o=0xDEADBEEF (N+2 with SRAM_RSP_REG_EN).
- A and B both request continuously for 6 cycles -> grants A,B,A,B,A,B; each rvalid goes to the matching side one cycle later; never both gnt.
- Partial write: B writes 0x10 with wmask 4'b0101, data 0x11223344; B reads 0x10 -> 0xDE22BE44.
- Idle for 3 cycles after traffic -> csb0=1, web0=1, no rvalid; pointer unchanged; the next simultaneous request is granted to the side not last granted.
- rst_ni asserted low in the cycle after a granted read -> rvalid stays 0 and csb0=1 immediately; after release, the first simultaneous request grants A.
